// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Holds a fetch PC, issues at most
//               one outstanding instruction-memory read, buffers responses in a
//               2-entry {pc, instr} FIFO for decode, and restarts the stream
//               on redirect_valid (branch/jump).
// Ports       : clk, rst                    - clock, synchronous active-high reset
//               redirect_valid/redirect_pc  - restart fetch at a new address
//               imem_req_valid/ready/addr   - memory read request channel
//               imem_rsp_valid/data         - memory read response (one per request)
//               if_valid/ready/instr/pc     - instruction handoff to decode
//               misalign_err                - sticky misaligned-redirect flag
//                                             (only with FETCH_MISALIGN_CHK_EN)
// Config      : `define FETCH_MISALIGN_CHK_EN to reject misaligned redirects
//               and expose misalign_err; otherwise the redirect target's low
//               two bits are forced to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                 pc_len       = 32,
    parameter int                 instr_len    = 32,
    parameter logic [pc_len-1:0]  reset_vector = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [pc_len-1:0]     redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [pc_len-1:0]     imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [instr_len-1:0]  imem_rsp_data,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [instr_len-1:0]  if_instr,
    output logic [pc_len-1:0]     if_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                  misalign_err
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;  // may issue a request
    localparam logic [1:0] S_WAIT = 2'd1;  // live request outstanding
    localparam logic [1:0] S_DROP = 2'd2;  // stale request outstanding

    localparam logic [1:0] c_FIFO_DEPTH = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_q, state_d;
    logic [pc_len-1:0]    pc_q, pc_d;
    logic [pc_len-1:0]    inflight_pc_q;   // address of the outstanding request

    logic [pc_len-1:0]    fifo_pc_q    [0:1];
    logic [instr_len-1:0] fifo_instr_q [0:1];
    logic                 rd_ptr_q;
    logic                 wr_ptr_q;
    logic [1:0]           count_q;

    // ------------------------------------------------------------------
    // Redirect qualification
    // ------------------------------------------------------------------
    logic                 w_redir;
    logic [pc_len-1:0]    w_target;

`ifdef FETCH_MISALIGN_CHK_EN
    logic                 w_misaligned;
    logic                 misalign_err_q;

    assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // A misaligned redirect is dropped entirely: the current stream keeps going.
    assign w_redir      = redirect_valid && !w_misaligned;
    assign w_target     = redirect_pc;
    assign misalign_err = misalign_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err_q <= 1'b0;
        end else if (w_misaligned) begin
            misalign_err_q <= 1'b1;
        end
    end
`else
    assign w_redir  = redirect_valid;
    // Word-align the target instead of rejecting it.
    assign w_target = redirect_pc & {{(pc_len-2){1'b1}}, 2'b00};
`endif

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic w_req_fire;
    logic w_push;
    logic w_pop;

    // Only one request may be in flight, so in S_REQ nothing is in flight and
    // a free slot simply means the FIFO is not full. Gated by rst so the
    // reset cycle never presents a request.
    assign imem_req_valid = !rst && (state_q == S_REQ) && (count_q != c_FIFO_DEPTH);
    assign imem_req_addr  = pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response arriving together with a redirect belongs to the old stream.
    assign w_push = (state_q == S_WAIT) && imem_rsp_valid && !w_redir;
    assign w_pop  = if_valid && if_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                // A request accepted in the redirect cycle targets the old
                // stream, so its response must be thrown away.
                if (w_req_fire) begin
                    state_d = w_redir ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                // The response closes the request whether kept or discarded.
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end else if (w_redir) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (w_redir) begin
            pc_d = w_target;
        end else if (w_req_fire) begin
            pc_d = pc_q + pc_len'(4);   // wraps modulo 2^pc_len
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= reset_vector;
            inflight_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (w_req_fire) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry response FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
        end else if (w_redir) begin
            // Flush: entries stay in place but become unreachable.
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
                fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign if_valid = (count_q != 2'd0);
    assign if_instr = fifo_instr_q[rd_ptr_q];
    assign if_pc    = fifo_pc_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter pc_len, default 32: width of all PC and address values.
REQ-002 Parameter instr_len, default 32: instruction word width.
REQ-003 Parameter reset_vector, default 0: first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc (branch/jump).
REQ-007 redirect_pc  input  pc_len  new fetch address.
REQ-008 imem_req_valid  output  1  memory read request valid.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_req_addr  output  pc_len  read address.
REQ-011 imem_rsp_valid  input  1  read data valid, one pulse per accepted request, latency >= 1 cycle.
REQ-012 imem_rsp_data  input  instr_len  read data.
REQ-013 if_valid  output  1  instruction available to decode.
REQ-014 if_ready  input  1  decode accepts instruction.
REQ-015 if_instr  output  instr_len  instruction at buffer head.
REQ-016 if_pc  output  pc_len  PC of if_instr.

Function
REQ-017 The block SHALL hold a fetch PC register; a request transfers when imem_req_valid && imem_req_ready, then fetch PC advances by 4, modulo 2^pc_len (0xFFFF_FFFC wraps to 0).
REQ-018 The block SHALL allow at most one outstanding memory request.
REQ-019 The block SHALL buffer responses in a 2-entry FIFO of {pc, instr}; decode transfer on if_valid && if_ready pops the head.
REQ-020 FSM states: REQ (imem_req_valid=1 iff FIFO has a free slot counting the in-flight entry), WAIT (request outstanding, imem_req_valid=0), DROP (stale request outstanding, imem_req_valid=0).
REQ-021 Transitions: REQ->WAIT on request transfer; WAIT->REQ on imem_rsp_valid (data pushed); WAIT->DROP on redirect_valid; DROP->REQ on imem_rsp_valid (data discarded).
REQ-022 redirect_valid SHALL flush the FIFO, deassert if_valid the next cycle, and load fetch PC with redirect_pc; a request transfer in the same cycle as redirect is treated as stale (REQ->DROP).
REQ-023 redirect_valid in DROP SHALL update fetch PC and remain in DROP.
REQ-024 Simultaneous push and pop on a full FIFO SHALL be permitted with no loss; on empty FIFO, response data SHALL appear on if_instr no earlier than the cycle after imem_rsp_valid (one-cycle registered latency).
REQ-025 imem_req_addr SHALL equal fetch PC whenever imem_req_valid=1 and SHALL be stable while valid && !ready.
REQ-026 if_instr/if_pc SHALL be stable while if_valid && !if_ready.

Reset
REQ-027 On rst: fetch PC=reset_vector, state=REQ, FIFO empty, if_valid=0, imem_req_valid=0 in the reset cycle, if_instr=0, if_pc=0.
REQ-028 Reset during WAIT/DROP SHALL abandon the outstanding request; a response arriving after reset deasserts with no request outstanding SHALL be ignored.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHK_EN: when defined, adds output misalign_err (1 bit) set sticky when redirect_valid with redirect_pc[1:0]!=0, cleared only by rst; the redirect is ignored (no flush, no PC change).
REQ-030 Without FETCH_MISALIGN_CHK_EN: no misalign_err port; redirect_pc low bits forced to 0 and redirect proceeds normally.

Verification
REQ-031 Reset, memory ready always, rsp latency 1, if_ready=1 -> addresses 0x0,0x4,0x8 issued; if_pc 0x0,0x4,0x8 in order with matching data.
REQ-032 if_ready=0 for 10 cycles -> FIFO fills to 2, imem_req_valid drops, no request issued; head held stable.
REQ-033 Redirect to 0x100 while WAIT at 0x8 -> 0x8 response discarded, next request 0x100, if_pc 0x100 next delivered.
REQ-034 Redirect to 0x40 while FIFO holds 2 entries -> if_valid=0 next cycle, next if_pc=0x40.
REQ-035 Fetch PC 0xFFFF_FFFC -> request transfer -> next imem_req_addr=0x0.
REQ-036 With FETCH_MISALIGN_CHK_EN, redirect to 0x102 -> misalign_err=1, fetch stream continues unchanged; rst clears it.
